// File: rtl/ahb_pkg.sv
// +----------------------------------------------------------------+
// | ahb_pkg : AHB transfer/burst/response codes and beat counting  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Undefined-length INCR is treated as one beat so it can be cut after any beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    logic [4:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_rr_picker.sv
// +----------------------------------------------------------------+
// | ahb_rr_picker : combinational round-robin selector with parking |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          last_idx,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [MW-1:0]          idx
);

  logic          found;
  logic [MW-1:0] cand;

  // Offset NUM_MASTERS lands back on last_idx, so a lone current requester keeps the bus.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = MW'(DEFAULT_MASTER);
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = MW'((int'(last_idx) + off) % NUM_MASTERS);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    grant = NUM_MASTERS'(1) << idx;
  end

endmodule

`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
// +----------------------------------------------------------------+
// | ahb_bus_arbiter : round-robin AHB arbiter, burst/lock aware     |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   Hclk,
  input  logic                   Hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic                   hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock
);

  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]          grant_idx_q, grant_idx_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic                   lock_q, lock_d;
  logic [4:0]             cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [MW-1:0]          pick_idx;
  logic                   owner_lock;
  logic                   rearb;

  ahb_rr_picker #(
    .NUM_MASTERS    (NUM_MASTERS),
    .DEFAULT_MASTER (DEFAULT_MASTER),
    .MW             (MW)
  ) u_picker (
    .req      (hbusreq),
    .last_idx (grant_idx_q),
    .grant    (pick_grant),
    .idx      (pick_idx)
  );

  assign owner_lock = hlock[grant_idx_q];

  // Remaining beats after this edge; an ERROR first cycle kills the burst.
  always_comb begin
    cnt_d = cnt_q;
    if (hresp == HRESP_ERROR && !hready) begin
      cnt_d = '0;
    end else if (hready) begin
      case (htrans)
        HTRANS_NONSEQ: cnt_d = burst_beats(hburst) - 5'd1;
        HTRANS_SEQ:    cnt_d = (cnt_q != 5'd0) ? cnt_q - 5'd1 : cnt_q;
        HTRANS_IDLE,
        HTRANS_BUSY:   cnt_d = cnt_q;
        default:       cnt_d = cnt_q;
      endcase
    end
  end

  assign rearb = hready && (cnt_d == 5'd0) && !owner_lock;

  always_comb begin
    hgrant_d    = hgrant_q;
    grant_idx_d = grant_idx_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    lock_d      = lock_q;
    if (hready) begin
      hmaster_d   = grant_idx_q;
      lock_d      = owner_lock;
      hmastlock_d = lock_q;
    end
    if (rearb) begin
      hgrant_d    = pick_grant;
      grant_idx_d = pick_idx;
    end
  end

  always_ff @(posedge Hclk or negedge Hreset) begin
    if (!Hreset) begin
      hgrant_q    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      grant_idx_q <= MW'(DEFAULT_MASTER);
      hmaster_q   <= MW'(DEFAULT_MASTER);
      hmastlock_q <= 1'b0;
      lock_q      <= 1'b0;
      cnt_q       <= 5'd0;
    end else begin
      hgrant_q    <= hgrant_d;
      grant_idx_q <= grant_idx_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

`default_nettype wire

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin AHB bus arbiter that shares one AHB bus between up to NUM_MASTERS requesters, such as ahb masters and the I2C bridge DMA side.
- Drives a one-hot grant, the current address-phase owner (hmaster) and hmastlock to the slave-side mux.
- Tracks burst beats so that fixed-length bursts and locked sequences are never split; hready stalls are honoured.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, index granted at reset and when nobody requests (bus parking)
MW, $clog2(NUM_MASTERS), width of hmaster

Ports:
Hclk  in  1  bus clock, all state changes on rising edge
Hreset  in  1  reset, asynchronous, active-low
hbusreq  in  NUM_MASTERS  per-master bus request
hlock  in  NUM_MASTERS  per-master locked-transfer request
htrans  in  2  transfer type on the muxed bus (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
hburst  in  3  burst type on the muxed bus
hready  in  1  transfer-done from the slave mux
hresp  in  1  1 = ERROR response
hgrant  out  NUM_MASTERS  one-hot grant
hmaster  out  MW  index of the master owning the current address phase
hmastlock  out  1  current address phase is locked

Behaviour:
- Reset (async, Hreset=0):
  - hgrant = 1<<DEFAULT_MASTER, hmaster = DEFAULT_MASTER, hmastlock = 0.
  - Beat counter cnt = 0; lock flag = 0.
- Accepted transfer: a rising edge with hready=1 and htrans in {NONSEQ, SEQ}.
- Burst beats: SINGLE=1; INCR=undefined, counted as 1; INCR4/WRAP4=4; INCR8/WRAP8=8; INCR16/WRAP16=16. cnt is 5 bits.
- Counter update:
  - Accepted NONSEQ: cnt <= beats-1.
  - Accepted SEQ with cnt>0: cnt <= cnt-1.
  - IDLE and BUSY: no change.
  - ERROR (hresp=1 and hready=0): cnt <= 0, which terminates the burst.
- States: OPEN (cnt_next==0 and no lock), BURST (cnt_next>0), LOCKED (lock flag=1). The state is derived from cnt and lock; no separate encoding.
- Lock flag: at each hready=1 edge, lock <= hlock[granted index]. hmastlock <= lock at the same edge.
- Re-arbitration happens only at a rising edge where all three hold:
  - hready=1,
  - cnt_next==0,
  - hlock[granted index]==0.
- Otherwise hgrant holds.
- Selection (combinational, evaluated at the re-arbitration edge):
  - Scan hbusreq from (granted index + 1) mod NUM_MASTERS, wrapping; first requester wins.
  - If only the current master requests, it keeps the grant.
  - If nobody requests, grant DEFAULT_MASTER.
- Ownership handover: at each hready=1 edge, hmaster <= granted index sampled before that edge's grant update. hmaster therefore lags hgrant by exactly one accepted cycle.
- Latency: request to hgrant is one edge when the bus is OPEN; hgrant to hmaster is the next hready=1 edge.
- hready=0 freezes hgrant, hmaster, hmastlock and cnt. The exception is the ERROR case above, which clears only cnt.
- An undefined-length INCR may lose the bus after any beat (cnt stays 0), which is legal AHB early termination.
- Simultaneous requests are resolved purely by the round-robin pointer; no master wins two consecutive arbitrations while another is requesting.
- Deasserting hbusreq mid fixed-length burst does not shorten the grant; the burst completes.
- Reset mid-burst returns immediately to the reset values, with no wait for hready.
- hgrant is always exactly one-hot; an all-zero grant is illegal. hmaster is always < NUM_MASTERS.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HBURST codes (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16).
  - Function burst_beats(hburst) returning 5 bits.
  - HRESP_OKAY/HRESP_ERROR constants.
- Sub-module ahb_rr_picker: combinational round-robin selector. Inputs are the request vector and the last index; outputs are the one-hot grant and the index. It contains the default-master fallback.

Test Plan:
- Reset check: Hreset low with all hbusreq=0, then release -> hgrant=4'b0001, hmaster=0, hmastlock=0; these hold with no requests.
- Round-robin: hbusreq=4'b1110 held, single transfers, hready=1 -> grants in order 1,2,3,1,2,3; hmaster follows one edge later.
- Fixed burst: master 2 issues INCR8 (NONSEQ + 7 SEQ) while master 3 requests -> hgrant stays on 2 for all 8 beats and moves to 3 during the 8th beat.
  - Repeat with hready=0 for 3 cycles mid-burst -> all outputs frozen; handover still occurs after beat 8.
- Locked sequence: master 1 with hlock=1 for two SINGLE transfers while 0 and 2 request -> no re-arbitration and hmastlock=1 for both data phases. Grant moves to 2 after hlock drops.
- ERROR termination: master 0 in WRAP4 receives hresp=1/hready=0 on beat 2 -> cnt cleared; at the next hready=1 edge, grant moves to requesting master 3.
- Mid-burst reset: assert Hreset during beat 3 of INCR16 -> outputs return to the reset values asynchronously, and the new arbitration starts from DEFAULT_MASTER.
